// File: rtl/alu_result_stage_pkg.sv
// Shared definitions for the ALU result stage.
//  - ALU opcode encoding (ADD_OP/SUB_OP are the only ops that produce N/V/Z flags)
//  - alu_result_t: one buffered {result, n, v, z} entry
//  - result_stage_state_t: occupancy state of the 2-entry skid buffer
package alu_result_stage_pkg;

    localparam int unsigned ALU_W = 4;

    localparam logic [ALU_W-1:0] ADD_OP = 4'h0;
    localparam logic [ALU_W-1:0] SUB_OP = 4'h1;
    localparam logic [ALU_W-1:0] AND_OP = 4'h2;
    localparam logic [ALU_W-1:0] OR_OP  = 4'h3;
    localparam logic [ALU_W-1:0] XOR_OP = 4'h4;
    localparam logic [ALU_W-1:0] NOT_OP = 4'h5;
    localparam logic [ALU_W-1:0] SHL_OP = 4'h6;
    localparam logic [ALU_W-1:0] SHR_OP = 4'h7;

    typedef struct packed {
        logic [ALU_W-1:0] result;
        logic             n;
        logic             v;
        logic             z;
    } alu_result_t;

    typedef enum logic [1:0] {
        RS_EMPTY = 2'd0,
        RS_ONE   = 2'd1,
        RS_TWO   = 2'd2
    } result_stage_state_t;

    // Only arithmetic ops feed the sticky status bits.
    function automatic logic is_flag_op(input logic [ALU_W-1:0] op);
        return (op == ADD_OP) || (op == SUB_OP);
    endfunction

endpackage

// File: rtl/alu_result_stage_skid.sv
// alu_skid_buffer: 2-entry valid/ready FIFO over alu_result_t.
// in_ready is a function of registered state only, so there is no combinational
// path from out_ready back to in_ready.
// Ports:
//  clk, rst_n             clock, async active-low reset
//  in_valid/in_ready      upstream handshake, in_data entry
//  out_valid/out_ready    downstream handshake, out_data is the head entry
module alu_skid_buffer
    import alu_result_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  alu_result_t in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output alu_result_t out_data
);

    result_stage_state_t state_q, state_d;
    alu_result_t         head_q, head_d;
    alu_result_t         tail_q, tail_d;
    // Low during reset and for the first edge after release, so in_ready
    // stays 0 until one cycle after rst_n rises.
    logic                released_q;

    logic accept_in;
    logic accept_out;

    assign in_ready   = released_q && (state_q != RS_TWO);
    assign out_valid  = (state_q != RS_EMPTY);
    assign out_data   = head_q;
    assign accept_in  = in_valid && in_ready;
    assign accept_out = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            RS_EMPTY: begin
                if (accept_in) begin
                    head_d  = in_data;
                    state_d = RS_ONE;
                end
            end
            RS_ONE: begin
                case ({accept_in, accept_out})
                    2'b10: begin
                        tail_d  = in_data;
                        state_d = RS_TWO;
                    end
                    2'b01: state_d = RS_EMPTY;
                    // Head drains while the new entry takes its place.
                    2'b11: head_d = in_data;
                    default: ;
                endcase
            end
            RS_TWO: begin
                if (accept_out) begin
                    head_d  = tail_q;
                    state_d = RS_ONE;
                end
            end
            default: state_d = RS_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RS_EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            released_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            released_q <= 1'b1;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered output stage behind the ALU flag calculator.
// Buffers up to two {result, N, V, Z} entries (alu_skid_buffer), keeps sticky
// N/V/Z bits over accepted ADD/SUB results and a saturating accepted-op count.
// Ports:
//  clk, rst_n                      clock, async active-low reset
//  in_valid/in_ready               upstream handshake
//  opcode, op_result, negative,
//  overflow, zero                  incoming op and its flags
//  out_valid/out_ready             downstream handshake
//  out_result, out_negative,
//  out_overflow, out_zero          head entry
//  sticky_n/v/z                    sticky status bits
//  clear_sticky                    sync clear of sticky bits and op_count
//  op_count                        saturating count of accepted ops
module alu_result_stage
    import alu_result_stage_pkg::*;
#(
    parameter int unsigned W     = ALU_W,  // must equal ALU_W (entry layout)
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     opcode,
    input  logic [W-1:0]     op_result,
    input  logic             negative,
    input  logic             overflow,
    input  logic             zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_result,
    output logic             out_negative,
    output logic             out_overflow,
    output logic             out_zero,
    output logic             sticky_n,
    output logic             sticky_v,
    output logic             sticky_z,
    input  logic             clear_sticky,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    alu_result_t in_entry;
    alu_result_t head_entry;
    logic        accept_in;
    logic        flag_op;

    logic [2:0]       sticky_q, sticky_d;  // {n, v, z}
    logic [CNT_W-1:0] count_q, count_d;

    assign in_entry.result = op_result;
    assign in_entry.n      = negative;
    assign in_entry.v      = overflow;
    assign in_entry.z      = zero;

    alu_skid_buffer u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_entry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head_entry)
    );

    assign out_result   = head_entry.result;
    assign out_negative = head_entry.n;
    assign out_overflow = head_entry.v;
    assign out_zero     = head_entry.z;

    assign accept_in = in_valid && in_ready;
    assign flag_op   = is_flag_op(opcode);

    // Clear is applied first, so a same-cycle accept lands on a cleared base.
    always_comb begin
        sticky_d = clear_sticky ? 3'b000 : sticky_q;
        count_d  = clear_sticky ? '0 : count_q;
        if (accept_in) begin
            if (flag_op) begin
                sticky_d = sticky_d | {negative, overflow, zero};
            end
            if (count_d != CntMax) begin
                count_d = count_d + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 3'b000;
            count_q  <= '0;
        end else begin
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    assign sticky_n = sticky_q[2];
    assign sticky_v = sticky_q[1];
    assign sticky_z = sticky_q[0];
    assign op_count = count_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed steps plus random traffic,
// checked against a queue-based reference model.
module tb_alu_result_stage;
    import alu_result_stage_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] opcode = '0;
    logic [3:0] op_result = '0;
    logic       negative = 1'b0;
    logic       overflow = 1'b0;
    logic       zero = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_result;
    logic       out_negative;
    logic       out_overflow;
    logic       out_zero;
    logic       sticky_n;
    logic       sticky_v;
    logic       sticky_z;
    logic       clear_sticky = 1'b0;
    logic [7:0] op_count;

    alu_result_stage #(.W(4), .CNT_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .opcode       (opcode),
        .op_result    (op_result),
        .negative     (negative),
        .overflow     (overflow),
        .zero         (zero),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_negative (out_negative),
        .out_overflow (out_overflow),
        .out_zero     (out_zero),
        .sticky_n     (sticky_n),
        .sticky_v     (sticky_v),
        .sticky_z     (sticky_z),
        .clear_sticky (clear_sticky),
        .op_count     (op_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] r;
        logic       n;
        logic       v;
        logic       z;
    } ent_t;

    // Reference model state
    ent_t       q[$];
    ent_t       emitted[$];
    logic [2:0] m_sticky = 3'b000;
    int         m_count = 0;
    bit         m_released = 1'b0;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_sticky   = 3'b000;
        m_count    = 0;
        m_released = 1'b0;
    endtask

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("in_ready", 32'(in_ready), 32'(m_released && q.size() < 2));
        if (q.size() > 0) begin
            chk("out_result", 32'(out_result), 32'(q[0].r));
            chk("out_negative", 32'(out_negative), 32'(q[0].n));
            chk("out_overflow", 32'(out_overflow), 32'(q[0].v));
            chk("out_zero", 32'(out_zero), 32'(q[0].z));
        end
        chk("sticky", 32'({sticky_n, sticky_v, sticky_z}), 32'(m_sticky));
        chk("op_count", 32'(op_count), 32'(m_count));
    endtask

    // Check at negedge, then advance model and DUT across one rising edge.
    task automatic cycle();
        bit   acc_in;
        bit   acc_out;
        ent_t e;
        @(negedge clk);
        check_outputs();
        acc_in  = in_valid && m_released && (q.size() < 2);
        acc_out = (q.size() > 0) && out_ready;
        e.r = op_result;
        e.n = negative;
        e.v = overflow;
        e.z = zero;
        @(posedge clk);
        if (rst_n) begin
            if (acc_out) emitted.push_back(q.pop_front());
            if (clear_sticky) begin
                m_sticky = 3'b000;
                m_count  = 0;
            end
            if (acc_in) begin
                q.push_back(e);
                if (opcode == ADD_OP || opcode == SUB_OP) m_sticky |= {e.n, e.v, e.z};
                if (m_count < 255) m_count++;
            end
            m_released = 1'b1;
        end
        #1;
    endtask

    task automatic drive(input bit v, input logic [3:0] op, input logic [3:0] r,
                         input bit n, input bit ov, input bit z);
        in_valid  = v;
        opcode    = op;
        op_result = r;
        negative  = n;
        overflow  = ov;
        zero      = z;
    endtask

    initial begin
        // 1 Reset held for 3 cycles
        model_reset();
        repeat (3) cycle();
        chk("reset_out_result", 32'(out_result), 32'h0);
        chk("reset_flags", 32'({out_negative, out_overflow, out_zero}), 32'h0);
        rst_n = 1'b1;
        cycle();
        chk("ready_after_release", 32'(in_ready), 32'h1);

        // 2 Pass-through
        out_ready = 1'b1;
        drive(1, ADD_OP, 4'h0, 0, 0, 1);
        cycle();
        drive(0, ADD_OP, 4'h0, 0, 0, 0);
        cycle();
        chk("pt_result", 32'(out_result), 32'h0);
        chk("pt_zero", 32'(out_zero), 32'h1);
        chk("pt_sticky_z", 32'(sticky_z), 32'h1);
        chk("pt_count", 32'(op_count), 32'h1);
        cycle();

        // 3 Backpressure: 3 and 5 accepted, 7 held until space frees
        emitted.delete();
        out_ready = 1'b0;
        drive(1, AND_OP, 4'h3, 0, 0, 0);
        cycle();
        drive(1, AND_OP, 4'h5, 0, 0, 0);
        cycle();
        drive(1, AND_OP, 4'h7, 0, 0, 0);
        cycle();
        chk("bp_in_ready_low", 32'(in_ready), 32'h0);
        cycle();
        out_ready = 1'b1;
        repeat (2) cycle();
        drive(0, AND_OP, 4'h0, 0, 0, 0);
        repeat (3) cycle();
        chk("bp_emit_count", 32'(emitted.size()), 32'd3);
        if (emitted.size() == 3) begin
            chk("bp_order0", 32'(emitted[0].r), 32'h3);
            chk("bp_order1", 32'(emitted[1].r), 32'h5);
            chk("bp_order2", 32'(emitted[2].r), 32'h7);
        end

        // 4 Sticky behaviour and clear with same-cycle accept
        drive(1, SUB_OP, 4'h9, 1, 0, 0);
        cycle();
        drive(1, AND_OP, 4'h1, 0, 0, 0);
        cycle();
        chk("st_sticky_n", 32'(sticky_n), 32'h1);
        drive(1, ADD_OP, 4'h2, 0, 0, 0);
        clear_sticky = 1'b1;
        cycle();
        clear_sticky = 1'b0;
        drive(0, ADD_OP, 4'h0, 0, 0, 0);
        chk("st_cleared_n", 32'(sticky_n), 32'h0);
        chk("st_count_one", 32'(op_count), 32'h1);
        repeat (2) cycle();

        // 5 Saturation
        for (int i = 0; i < 300; i++) begin
            drive(1, 4'($urandom_range(0, 15)), 4'($urandom), 0, 0, 0);
            cycle();
        end
        drive(0, ADD_OP, 4'h0, 0, 0, 0);
        repeat (3) cycle();
        chk("sat_count", 32'(op_count), 32'd255);

        // 6 Async reset while holding two entries
        out_ready = 1'b0;
        drive(1, ADD_OP, 4'hA, 1, 1, 0);
        cycle();
        drive(1, SUB_OP, 4'hB, 0, 1, 1);
        cycle();
        drive(0, ADD_OP, 4'h0, 0, 0, 0);
        chk("ar_full", 32'(out_valid && !in_ready), 32'h1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("ar_out_valid_now", 32'(out_valid), 32'h0);
        chk("ar_count_now", 32'(op_count), 32'h0);
        out_ready = 1'b1;
        cycle();
        rst_n = 1'b1;
        emitted.delete();
        repeat (4) cycle();
        chk("ar_nothing_emitted", 32'(emitted.size()), 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 4'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
            out_ready    = 1'($urandom_range(0, 2) != 0);
            clear_sticky = 1'($urandom_range(0, 15) == 0);
            cycle();
        end
        clear_sticky = 1'b0;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        repeat (3) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
